// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter for a bank of DEPTH enable-gated W-bit registers.
// NREQ requesters present (addr, data) over valid/ready. At most one write is granted per cycle,
// and the granted write appears one cycle later on a registered one-hot wr_en and a shared
// wr_data bus.
// Optional feature: define REG_ARB_STATS_EN to add per-requester saturating accept counters
// (grant_cnt) with a synchronous clear (stats_clr).

module reg_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned SW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0]  req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               bank_busy,
  output logic [DEPTH-1:0]   wr_en,
  output logic [W-1:0]       wr_data,
  output logic [SW-1:0]      wr_src,
  output logic               addr_err
`ifdef REG_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt,
  input  logic               stats_clr
`endif
);

  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DEPTH-1:0] wr_en_q, wr_en_d;
  logic [W-1:0]     wr_data_q, wr_data_d;
  logic [SW-1:0]    wr_src_q, wr_src_d;
  logic             addr_err_q, addr_err_d;

  logic [NREQ-1:0]  grant;
  logic [SW-1:0]    gnt_idx;
  logic             accept;
  logic [AW-1:0]    sel_addr;
  logic [W-1:0]     sel_data;
  int unsigned      idx;
  int unsigned      nxt;
  logic [SW-1:0]    cur;

  // Round-robin search starting at rr_ptr; the first valid requester wins unless the bank stalls.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    accept  = 1'b0;
    idx     = 0;
    cur     = '0;
    if (!bank_busy) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        cur = SW'(idx);
        if (!accept && req_valid[cur]) begin
          accept       = 1'b1;
          grant[cur]   = 1'b1;
          gnt_idx      = cur;
        end
      end
    end
  end

  assign req_ready = grant;
  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign sel_data  = req_data[gnt_idx*W +: W];

  // Pointer moves to the requester after the winner; it holds when nothing is accepted.
  always_comb begin
    nxt      = 32'(gnt_idx) + 1;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (nxt == NREQ) ? '0 : SW'(nxt);
    end
  end

  // Next write stage: an out-of-range address is still consumed but raises addr_err instead of
  // enabling a register, so a bad requester cannot deadlock the arbiter.
  always_comb begin
    wr_en_d = '0;
    for (int unsigned d = 0; d < DEPTH; d++) begin
      wr_en_d[d] = accept && (32'(sel_addr) == d);
    end
    addr_err_d = accept && (32'(sel_addr) >= DEPTH);
    wr_data_d  = accept ? sel_data : wr_data_q;
    wr_src_d   = accept ? gnt_idx : wr_src_q;
  end

  // Pointer and output register stage; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;
  assign addr_err = addr_err_q;

`ifdef REG_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  // Saturating per-requester accept counters; a clear beats a same-cycle increment.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (grant[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack counters, requester i at [i*16 +: 16].
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule
